// File: rtl/multiply8_unsigned_arbiter_pkg.sv
// Shared definitions for the two-requester 8x8 unsigned multiplier front end:
// operand/product widths, requester ID type, pipeline payload structs and the
// carry-save helpers used by the Wallace-tree reduction.
package multiply8_unsigned_arbiter_pkg;

    localparam int OPND_W     = 8;
    localparam int PROD_W     = 16;
    localparam int MUL8_TAG_W = 4;

    // Requester identifier: 0 or 1.
    typedef logic req_id_t;

    // S1 holds the operands of the accepted request plus its routing info.
    typedef struct packed {
        logic [OPND_W-1:0]     a;
        logic [OPND_W-1:0]     b;
        req_id_t               id;
        logic [MUL8_TAG_W-1:0] tag;
    } s1_payload_t;

    // S2 holds the finished product plus the same routing info.
    typedef struct packed {
        logic [PROD_W-1:0]     product;
        req_id_t               id;
        logic [MUL8_TAG_W-1:0] tag;
    } s2_payload_t;

    localparam s1_payload_t S1_EMPTY = '{
        a:   {OPND_W{1'b0}},
        b:   {OPND_W{1'b0}},
        id:  1'b0,
        tag: {MUL8_TAG_W{1'b0}}
    };

    localparam s2_payload_t S2_EMPTY = '{
        product: {PROD_W{1'b0}},
        id:      1'b0,
        tag:     {MUL8_TAG_W{1'b0}}
    };

    // Sum row of a 3:2 carry-save compressor applied across a whole row.
    function automatic logic [PROD_W-1:0] csa_sum(
        input logic [PROD_W-1:0] x,
        input logic [PROD_W-1:0] y,
        input logic [PROD_W-1:0] z
    );
        return x ^ y ^ z;
    endfunction

    // Carry row of a 3:2 compressor, already moved to the next weight.
    // Carries leaving bit 15 are dropped: the exact product fits in 16 bits,
    // so the modular sum of the rows is still the true product.
    function automatic logic [PROD_W-1:0] csa_carry(
        input logic [PROD_W-1:0] x,
        input logic [PROD_W-1:0] y,
        input logic [PROD_W-1:0] z
    );
        return ((x & y) | (x & z) | (y & z)) << 1;
    endfunction

    // One partial-product row: a gated by a single multiplier bit, at its weight.
    function automatic logic [PROD_W-1:0] partial_product(
        input logic [OPND_W-1:0] a,
        input logic              b_bit,
        input int unsigned       weight
    );
        logic [PROD_W-1:0] row;
        row = {{(PROD_W-OPND_W){1'b0}}, a & {OPND_W{b_bit}}};
        return row << weight;
    endfunction

endpackage

// File: rtl/multiply8_unsigned_wallace_tree_without_loop.sv
// Combinational 8x8 unsigned multiplier. Eight partial-product rows are
// reduced with row-wide 3:2 compressors (8 -> 6 -> 4 -> 3 -> 2 rows) and the
// last two rows are summed with a single carry-propagate adder. Every stage is
// written out explicitly so the tree shape is visible in the source.
module multiply8_unsigned_wallace_tree_without_loop
    import multiply8_unsigned_arbiter_pkg::*;
(
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    output logic [PROD_W-1:0] product
);

    logic [PROD_W-1:0] pp0_s, pp1_s, pp2_s, pp3_s, pp4_s, pp5_s, pp6_s, pp7_s;
    logic [PROD_W-1:0] l1_sum_a_s, l1_car_a_s, l1_sum_b_s, l1_car_b_s;
    logic [PROD_W-1:0] l2_sum_a_s, l2_car_a_s, l2_sum_b_s, l2_car_b_s;
    logic [PROD_W-1:0] l3_sum_s, l3_car_s;
    logic [PROD_W-1:0] l4_sum_s, l4_car_s;

    // Partial-product generation, one row per multiplier bit.
    assign pp0_s = partial_product(a, b[0], 32'd0);
    assign pp1_s = partial_product(a, b[1], 32'd1);
    assign pp2_s = partial_product(a, b[2], 32'd2);
    assign pp3_s = partial_product(a, b[3], 32'd3);
    assign pp4_s = partial_product(a, b[4], 32'd4);
    assign pp5_s = partial_product(a, b[5], 32'd5);
    assign pp6_s = partial_product(a, b[6], 32'd6);
    assign pp7_s = partial_product(a, b[7], 32'd7);

    // Level 1: 8 rows -> 6 rows (pp6/pp7 pass through).
    assign l1_sum_a_s = csa_sum  (pp0_s, pp1_s, pp2_s);
    assign l1_car_a_s = csa_carry(pp0_s, pp1_s, pp2_s);
    assign l1_sum_b_s = csa_sum  (pp3_s, pp4_s, pp5_s);
    assign l1_car_b_s = csa_carry(pp3_s, pp4_s, pp5_s);

    // Level 2: 6 rows -> 4 rows.
    assign l2_sum_a_s = csa_sum  (l1_sum_a_s, l1_car_a_s, l1_sum_b_s);
    assign l2_car_a_s = csa_carry(l1_sum_a_s, l1_car_a_s, l1_sum_b_s);
    assign l2_sum_b_s = csa_sum  (l1_car_b_s, pp6_s, pp7_s);
    assign l2_car_b_s = csa_carry(l1_car_b_s, pp6_s, pp7_s);

    // Level 3: 4 rows -> 3 rows (l2_car_b passes through).
    assign l3_sum_s = csa_sum  (l2_sum_a_s, l2_car_a_s, l2_sum_b_s);
    assign l3_car_s = csa_carry(l2_sum_a_s, l2_car_a_s, l2_sum_b_s);

    // Level 4: 3 rows -> 2 rows.
    assign l4_sum_s = csa_sum  (l3_sum_s, l3_car_s, l2_car_b_s);
    assign l4_car_s = csa_carry(l3_sum_s, l3_car_s, l2_car_b_s);

    // Final carry-propagate addition.
    assign product = l4_sum_s + l4_car_s;

endmodule

// File: rtl/multiply8_unsigned_arbiter.sv
// Two-requester front end for a shared 8x8 unsigned multiplier.
// Pipeline: S1 (operands, id, tag) -> combinational multiplier -> S2 (product,
// id, tag). S2 drives the response channel directly, so resp_* are registered.
// Request readys are combinational from the valids, resp_ready and S1/S2 state.
// Build option: define MUL8_ARB_ROUND_ROBIN_EN for a round-robin pointer that
// alternates the winner when both requesters are valid; otherwise requester 0
// has fixed priority and the pointer register is not built.
module multiply8_unsigned_arbiter
    import multiply8_unsigned_arbiter_pkg::*;
#(
    parameter int TAG_W = MUL8_TAG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OPND_W-1:0] req0_a,
    input  logic [OPND_W-1:0] req0_b,
    input  logic [TAG_W-1:0]  req0_tag,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OPND_W-1:0] req1_a,
    input  logic [OPND_W-1:0] req1_b,
    input  logic [TAG_W-1:0]  req1_tag,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [PROD_W-1:0] resp_product,
    output req_id_t           resp_id,
    output logic [TAG_W-1:0]  resp_tag
);

    s1_payload_t       s1_r;
    s1_payload_t       s1_next_s;
    logic              s1_valid_r;
    s2_payload_t       s2_r;
    s2_payload_t       s2_next_s;
    logic              s2_valid_r;
    logic              s2_free_s;
    logic              s1_free_s;
    req_id_t           grant_s;
    logic              accept_s;
    logic [PROD_W-1:0] product_s;

    // A stage may load when it is empty or its contents move on this cycle.
    assign s2_free_s = !s2_valid_r || resp_ready;
    assign s1_free_s = !s1_valid_r || s2_free_s;

`ifdef MUL8_ARB_ROUND_ROBIN_EN
    req_id_t prio_r;

    // Pick the requester that owns the next S1 slot (pointer breaks ties).
    always_comb begin
        grant_s = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_s = prio_r;
        end else if (req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Tie-break pointer: after every accepted request the other port is favoured.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_r <= 1'b0;
        end else if (accept_s) begin
            prio_r <= ~grant_s;
        end
    end
`else
    // Pick the requester that owns the next S1 slot (port 0 always wins ties).
    always_comb begin
        grant_s = 1'b0;
        if (req0_valid) begin
            grant_s = 1'b0;
        end else if (req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end
`endif

    // Readys are held low throughout reset so nothing is accepted into a
    // pipeline that is being cleared.
    assign req0_ready = !rst && s1_free_s && (grant_s == 1'b0) && req0_valid;
    assign req1_ready = !rst && s1_free_s && (grant_s == 1'b1) && req1_valid;
    assign accept_s   = req0_ready || req1_ready;

    // Steer the granted request's operands, id and tag toward S1.
    always_comb begin
        s1_next_s = S1_EMPTY;
        case (grant_s)
            1'b0: s1_next_s = '{a: req0_a, b: req0_b, id: 1'b0, tag: req0_tag};
            1'b1: s1_next_s = '{a: req1_a, b: req1_b, id: 1'b1, tag: req1_tag};
            default: s1_next_s = S1_EMPTY;
        endcase
    end

    // S1 operand register: takes the granted request whenever the slot frees up.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_r       <= S1_EMPTY;
        end else if (s1_free_s) begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_r <= s1_next_s;
            end
        end
    end

    multiply8_unsigned_wallace_tree_without_loop u_mul (
        .a       (s1_r.a),
        .b       (s1_r.b),
        .product (product_s)
    );

    assign s2_next_s = '{product: product_s, id: s1_r.id, tag: s1_r.tag};

    // S2 result register: loads from S1 when free; otherwise holds the
    // presented response stable under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            s2_r       <= S2_EMPTY;
        end else if (s2_free_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_r <= s2_next_s;
            end
        end
    end

    assign resp_valid   = s2_valid_r;
    assign resp_product = s2_r.product;
    assign resp_id      = s2_r.id;
    assign resp_tag     = s2_r.tag;

endmodule

// File: tb/tb_multiply8_unsigned_arbiter.sv
// Scoreboard bench for multiply8_unsigned_arbiter. The stimulus process drives
// directed and random traffic; a negedge monitor records every request
// handshake (expected a*b, id, tag) into a queue, checks the arbitration
// winner against the priority rule, and pops/compares on every response
// handshake. Follows MUL8_ARB_ROUND_ROBIN_EN the same way the design does.
module tb_multiply8_unsigned_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [7:0]  req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_tag, req1_tag;
    logic        resp_valid, resp_ready;
    logic [15:0] resp_product;
    logic        resp_id;
    logic [3:0]  resp_tag;

    typedef struct {
        logic [15:0] product;
        logic        id;
        logic [3:0]  tag;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic        mprio  = 1'b0;
    logic        hold_v = 1'b0;
    logic [15:0] hold_p;
    logic        hold_id;
    logic [3:0]  hold_tag;

    multiply8_unsigned_arbiter #(.TAG_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req0_tag     (req0_tag),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .req1_tag     (req1_tag),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_product (resp_product),
        .resp_id      (resp_id),
        .resp_tag     (resp_tag)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: samples mid-cycle, ahead of the edge that completes handshakes.
    always @(negedge clk) begin
        exp_t e;
        logic exp_w;
        if (rst) begin
            exp_q.delete();
            mprio  = 1'b0;
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("hold_valid",   {31'd0, resp_valid}, 32'd1);
                check("hold_product", {16'd0, resp_product}, {16'd0, hold_p});
                check("hold_id",      {31'd0, resp_id}, {31'd0, hold_id});
                check("hold_tag",     {28'd0, resp_tag}, {28'd0, hold_tag});
            end
            if (resp_valid && !resp_ready) begin
                hold_v   = 1'b1;
                hold_p   = resp_product;
                hold_id  = resp_id;
                hold_tag = resp_tag;
            end else begin
                hold_v = 1'b0;
            end
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL resp_unexpected: got product 0x%0h id %0d tag 0x%0h, expected no response",
                             resp_product, resp_id, resp_tag);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_product", {16'd0, resp_product}, {16'd0, e.product});
                    check("resp_id",      {31'd0, resp_id}, {31'd0, e.id});
                    check("resp_tag",     {28'd0, resp_tag}, {28'd0, e.tag});
                end
            end
            if (req0_ready || req1_ready) begin
                check("single_ready", {31'd0, req0_ready & req1_ready}, 32'd0);
                check("ready_without_valid",
                      {31'd0, (req0_ready & !req0_valid) | (req1_ready & !req1_valid)}, 32'd0);
                if (req0_valid && req1_valid) begin
`ifdef MUL8_ARB_ROUND_ROBIN_EN
                    exp_w = mprio;
`else
                    exp_w = 1'b0;
`endif
                end else begin
                    exp_w = req1_valid;
                end
                check("grant_winner", {31'd0, req1_ready}, {31'd0, exp_w});
                if (req1_ready) begin
                    e.product = 16'(req1_a) * 16'(req1_b);
                    e.id      = 1'b1;
                    e.tag     = req1_tag;
                end else begin
                    e.product = 16'(req0_a) * 16'(req0_b);
                    e.id      = 1'b0;
                    e.tag     = req0_tag;
                end
                exp_q.push_back(e);
                mprio = ~req1_ready;
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic port, input logic [7:0] a, input logic [7:0] b, input logic [3:0] tag);
        int   n   = 0;
        logic got = 1'b0;
        if (port) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_tag = tag;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_tag = tag;
        end
        while (!got && n < 50) begin
            @(negedge clk);
            n++;
            got = port ? req1_ready : req0_ready;
        end
        if (!got) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: port %0d not accepted after %0d cycles, expected acceptance", port, n);
        end
        next_cycle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        resp_ready = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        while ((exp_q.size() != 0 || resp_valid) && n < 100) begin
            next_cycle();
            n++;
        end
        check("drain_left_in_queue", exp_q.size(), 32'd0);
        check("drain_resp_valid", {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        int lat;
        int acc;
        rst = 1'b1;
        resp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 8'h12; req0_b = 8'h34; req0_tag = 4'h1;
        req1_valid = 1'b1; req1_a = 8'h56; req1_b = 8'h78; req1_tag = 4'h2;

        // Reset held 3 cycles with both requesters valid.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_req0_ready",   {31'd0, req0_ready}, 32'd0);
            check("rst_req1_ready",   {31'd0, req1_ready}, 32'd0);
            check("rst_resp_valid",   {31'd0, resp_valid}, 32'd0);
            check("rst_resp_product", {16'd0, resp_product}, 32'd0);
            check("rst_resp_id",      {31'd0, resp_id}, 32'd0);
            check("rst_resp_tag",     {28'd0, resp_tag}, 32'd0);
        end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("first_grant_req0", {31'd0, req0_ready}, 32'd1);
        check("first_grant_req1", {31'd0, req1_ready}, 32'd0);
        next_cycle();
        drain();

        // Single request, two-edge latency, 0xFF*0xFF.
        send(1'b0, 8'hFF, 8'hFF, 4'h3);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid && lat < 10);
        check("latency_cycles", lat, 32'd2);
        next_cycle();
        drain();

        // Both valid continuously with resp_ready high: one accept per cycle.
        req0_a = 8'h80; req0_b = 8'h80;
        req1_a = 8'h10; req1_b = 8'h10;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            req0_tag = 4'(i);
            req1_tag = 4'(15 - i);
            @(negedge clk);
            if (req0_ready || req1_ready) acc++;
            next_cycle();
        end
        check("full_throughput_accepts", acc, 32'd8);
        drain();

        // Backpressure: 4 cycles with resp_ready low, both valid.
        resp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 8'h21; req0_b = 8'h43; req0_tag = 4'h7;
        req1_valid = 1'b1; req1_a = 8'h65; req1_b = 8'h87; req1_tag = 4'h8;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) acc++;
            next_cycle();
        end
        check("backpressure_accepts", acc, 32'd2);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        next_cycle();
        next_cycle();
        drain();

        // Reset while S1 and S2 are both full.
        resp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 8'h33; req0_b = 8'h44; req0_tag = 4'h9;
        req1_valid = 1'b1; req1_a = 8'h55; req1_b = 8'h66; req1_tag = 4'hA;
        next_cycle();
        next_cycle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b1;
        next_cycle();
        @(negedge clk);
        check("mid_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        next_cycle();
        rst = 1'b0;
        resp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_no_resp", {31'd0, resp_valid}, 32'd0);
            next_cycle();
        end
        send(1'b1, 8'h5A, 8'h03, 4'hC);
        drain();

        // Edge operands through port 1.
        send(1'b1, 8'h00, 8'hAB, 4'h4);
        send(1'b1, 8'h01, 8'h01, 4'h5);
        send(1'b1, 8'hFE, 8'hFE, 4'h6);
        drain();

        // Randomised traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            req0_valid = ($urandom_range(0, 9) < 6);
            req1_valid = ($urandom_range(0, 9) < 6);
            req0_a = 8'($urandom); req0_b = 8'($urandom); req0_tag = 4'($urandom);
            req1_a = 8'($urandom); req1_b = 8'($urandom); req1_tag = 4'($urandom);
            resp_ready = ($urandom_range(0, 9) < 7);
            next_cycle();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
        $fatal(1);
    end

endmodule
